dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- MEM-stage load/store sequencer between the pipeline's M stage and a variable-latency data memory using a req/ack handshake.
- Stores: generates byte write enables and lane-replicated write data.
- Loads: returns the raw 32-bit word plus byte offset and load type, registered into W stage, feeding the load-data extension logic.
- Stalls the pipeline while an access is outstanding; flags misaligned accesses and ack timeouts.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT_CYCLES, 255, max BUSY cycles before abandoning an access; 0 disables the timeout.

Ports:
- CPU_CLK  in  1  clock.
- CPU_RSTn  in  1  asynchronous reset, active-low.
- MemReadM  in  1  M-stage instruction is a load.
- LoadTypeM  in  3  register-write mode of the load: LB/LH/LW/LBU/LHU.
- StoreTypeM  in  2  00 none, 01 SB, 10 SH, 11 SW.
- AddrM  in  ADDR_W  byte address (ALU result).
- StoreDataM  in  32  store source register value.
- DMemReq  out  1  request to data memory.
- DMemAddr  out  ADDR_W-2  word address.
- DMemWe  out  4  byte write enables; 0000 for a load.
- DMemWData  out  32  lane-aligned store data.
- DMemAck  in  1  one-cycle completion pulse.
- DMemRData  in  32  read word, valid with DMemAck.
- StallMem  out  1  freeze IF..M stages.
- MisalignM  out  1  combinational misalignment flag for the current M instruction.
- BusErr  out  1  one-cycle pulse on timeout.
- LoadDataW  out  32  raw loaded word.
- LoadedBytesSelectW  out  2  AddrM[1:0] of the completed load.
- LoadTypeW  out  3  load mode of the completed load.
- LoadValidW  out  1  W-stage load data is valid.

Behaviour:
- Reset (asynchronous, CPU_RSTn=0):
  - FSM returns to IDLE.
  - DMemReq=0, DMemWe=0, DMemAddr=0, DMemWData=0, BusErr=0.
  - LoadDataW=0, LoadedBytesSelectW=0, LoadTypeW=0, LoadValidW=0.
  - StallMem=0.
  - An ack arriving after reset is ignored; ack is only honoured in BUSY.
- Access condition: MemReadM=1 or StoreTypeM!=00.
- Load and store both requested: the store wins and the load is ignored. This is illegal; the bench flags it.
- Misalignment (combinational):
  - Misaligned when AddrM[0]=1 for LH/LHU/SH, or AddrM[1:0]!=00 for LW/SW.
  - Result: MisalignM=1, no request, no stall, no write.
  - A misaligned load completes with LoadValidW=0.
- FSM IDLE:
  - On an aligned access, StallMem=1 combinationally.
  - Latch the following: AddrM[ADDR_W-1:2] into DMemAddr, the byte enables, the write data, AddrM[1:0], LoadTypeM, and the load flag.
  - Go to BUSY.
- FSM BUSY:
  - DMemReq=1 and StallMem=1. Address, enables and data stay stable until ack.
  - Timeout counter increments each cycle.
  - On DMemAck: capture DMemRData (loads only), go to DONE.
  - If the counter reaches TIMEOUT_CYCLES without ack: pulse BusErr, drop the request, go to DONE with the load marked invalid.
- FSM DONE:
  - DMemReq=0, DMemWe=0, StallMem=0. The held instruction advances at this edge.
  - No new access is accepted in DONE, which prevents a re-issue.
  - W outputs load at this edge. LoadValidW=1 only for a completed, non-timed-out load; otherwise 0.
  - Go to IDLE.
- Pipeline advance without a memory access: LoadValidW is cleared on that edge.
- Byte enables and write data:
  - SB: DMemWe=0001<<AddrM[1:0]; DMemWData={4{StoreDataM[7:0]}}.
  - SH: DMemWe=0011<<AddrM[1:0]; DMemWData={2{StoreDataM[15:0]}}.
  - SW: DMemWe=1111; DMemWData=StoreDataM.
- Latency: the accept cycle is T0. With ack in the first BUSY cycle (T1), DONE is T2. Minimum stall is 2 cycles; each extra wait cycle adds 1.
- Timeout counter: width $clog2(TIMEOUT_CYCLES+1); cleared on entering BUSY.
- Timeout and ack in the same cycle: the ack wins and BusErr stays 0.

Decomposition:
- Parameters.v (shared include) holds:
  - Load codes NOREGWRITE=3'd0, LB=3'd1, LH=3'd2, LW=3'd3, LBU=3'd4, LHU=3'd5.
  - Store codes SNONE/SB/SH/SW = 2'd0..3.
  - FSM state codes IDLE/BUSY/DONE.
- One sub-module, store_lane_gen (combinational): byte-enable and write-data replication, plus misalignment detection.

Test Plan:
- SB at 0x1003 with data 0x000000AB, ack after 1 cycle -> DMemAddr=0x400, DMemWe=1000, DMemWData=0xABABABAB, StallMem high for 2 cycles, LoadValidW=0.
- LH at 0x2002 (LoadTypeM=LH), DMemRData=0x8001_7FFF, ack after 4 cycles -> StallMem high for 5 cycles; then LoadDataW=0x80017FFF, LoadedBytesSelectW=10, LoadTypeW=LH, LoadValidW=1.
- LW at 0x0006 -> MisalignM=1, DMemReq never asserted, StallMem=0, LoadValidW=0.
- TIMEOUT_CYCLES=8 with no ack -> BusErr pulses once after 8 BUSY cycles, DMemReq drops, FSM returns to IDLE, LoadValidW=0.
- CPU_RSTn low in the 2nd BUSY cycle, then ack 1 cycle after release -> all outputs 0 immediately, late ack ignored, no W update.
- Back-to-back SW 0x10 followed by LBU 0x13 -> the second request starts only after DONE; DMemAddr 0x4 twice, DMemWe 1111 then 0000; no duplicate store.

Source files
------------

// File: rtl/dmem_access_unit_pkg.sv
// Shared load/store encodings and FSM state type for the MEM-stage access unit.
package dmem_access_unit_pkg;

  localparam logic [2:0] NOREGWRITE = 3'd0;
  localparam logic [2:0] LB         = 3'd1;
  localparam logic [2:0] LH         = 3'd2;
  localparam logic [2:0] LW         = 3'd3;
  localparam logic [2:0] LBU        = 3'd4;
  localparam logic [2:0] LHU        = 3'd5;

  localparam logic [1:0] SNONE = 2'd0;
  localparam logic [1:0] SB    = 2'd1;
  localparam logic [1:0] SH    = 2'd2;
  localparam logic [1:0] SW    = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_access_unit_if.sv
// Data-memory bus between the access unit (master) and the memory (slave).
interface dmem_access_unit_if #(
  parameter int ADDR_W = 32
) ();
  // Handshake: DMemReq is held high with DMemAddr/DMemWe/DMemWData stable
  // until the memory returns a single-cycle DMemAck; DMemRData is valid only
  // in the DMemAck cycle. Req drops on the edge that samples the ack.
  logic              DMemReq;
  logic [ADDR_W-3:0] DMemAddr;
  logic [3:0]        DMemWe;
  logic [31:0]       DMemWData;
  logic              DMemAck;
  logic [31:0]       DMemRData;

  modport master (
    output DMemReq, DMemAddr, DMemWe, DMemWData,
    input  DMemAck, DMemRData
  );

  modport slave (
    input  DMemReq, DMemAddr, DMemWe, DMemWData,
    output DMemAck, DMemRData
  );
endinterface

// File: rtl/dmem_access_unit_store_lane_gen.sv
// Byte-enable / lane replication for stores and alignment check for the M instruction.
module dmem_access_unit_store_lane_gen
  import dmem_access_unit_pkg::*;
(
  input  logic        mem_read,
  input  logic [2:0]  load_type,
  input  logic [1:0]  store_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [3:0]  we,
  output logic [31:0] wdata,
  output logic        misalign
);

  logic is_store;
  logic is_load;

  // A store outranks a simultaneous load, so the load's alignment is moot.
  assign is_store = (store_type != SNONE);
  assign is_load  = mem_read && !is_store;

  always_comb begin
    we       = 4'b0000;
    wdata    = 32'h0;
    misalign = 1'b0;
    if (is_store) begin
      case (store_type)
        SB: begin
          we    = 4'b0001 << addr_lo;
          wdata = {4{store_data[7:0]}};
        end
        SH: begin
          misalign = addr_lo[0];
          we       = 4'b0011 << addr_lo;
          wdata    = {2{store_data[15:0]}};
        end
        SW: begin
          misalign = (addr_lo != 2'b00);
          we       = 4'b1111;
          wdata    = store_data;
        end
        default: ;
      endcase
    end else if (is_load) begin
      case (load_type)
        LH, LHU: misalign = addr_lo[0];
        LW:      misalign = (addr_lo != 2'b00);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store sequencer: issues req/ack accesses, stalls the pipe,
// and registers the raw load word plus its offset/type into the W stage.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RSTn,
  input  logic              MemReadM,
  input  logic [2:0]        LoadTypeM,
  input  logic [1:0]        StoreTypeM,
  input  logic [ADDR_W-1:0] AddrM,
  input  logic [31:0]       StoreDataM,
  dmem_access_unit_if.master dmem,
  output logic              StallMem,
  output logic              MisalignM,
  output logic              BusErr,
  output logic [31:0]       LoadDataW,
  output logic [1:0]        LoadedBytesSelectW,
  output logic [2:0]        LoadTypeW,
  output logic              LoadValidW,
  output state_t            dbg_state
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t            state;
  logic              req_q;
  logic [ADDR_W-3:0] addr_q;
  logic [3:0]        we_q;
  logic [31:0]       wdata_q;
  logic [1:0]        bsel_q;
  logic [2:0]        ltype_q;
  logic              ld_flag_q;
  logic              timed_out_q;
  logic [31:0]       rdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;
  logic        lane_misalign;
  logic        access;
  logic        is_load;
  logic        go;

  dmem_access_unit_store_lane_gen u_lane (
    .mem_read   (MemReadM),
    .load_type  (LoadTypeM),
    .store_type (StoreTypeM),
    .addr_lo    (AddrM[1:0]),
    .store_data (StoreDataM),
    .we         (lane_we),
    .wdata      (lane_wdata),
    .misalign   (lane_misalign)
  );

  assign access    = MemReadM || (StoreTypeM != SNONE);
  assign is_load   = MemReadM && (StoreTypeM == SNONE);
  assign MisalignM = access && lane_misalign;
  // Reset gating keeps the stall low while CPU_RSTn is held, even with an access pending.
  assign go        = CPU_RSTn && (state == IDLE) && access && !lane_misalign;
  assign StallMem  = go || (state == BUSY);

  assign dmem.DMemReq   = req_q;
  assign dmem.DMemAddr  = addr_q;
  assign dmem.DMemWe    = we_q;
  assign dmem.DMemWData = wdata_q;
  assign dbg_state      = state;

  always_ff @(posedge CPU_CLK or negedge CPU_RSTn) begin
    if (!CPU_RSTn) begin
      state              <= IDLE;
      req_q              <= 1'b0;
      addr_q             <= '0;
      we_q               <= 4'b0000;
      wdata_q            <= 32'h0;
      bsel_q             <= 2'b00;
      ltype_q            <= NOREGWRITE;
      ld_flag_q          <= 1'b0;
      timed_out_q        <= 1'b0;
      rdata_q            <= 32'h0;
      cnt_q              <= '0;
      BusErr             <= 1'b0;
      LoadDataW          <= 32'h0;
      LoadedBytesSelectW <= 2'b00;
      LoadTypeW          <= NOREGWRITE;
      LoadValidW         <= 1'b0;
    end else begin
      BusErr     <= 1'b0;
      LoadValidW <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state       <= BUSY;
            req_q       <= 1'b1;
            addr_q      <= AddrM[ADDR_W-1:2];
            we_q        <= lane_we;
            wdata_q     <= lane_wdata;
            bsel_q      <= AddrM[1:0];
            ltype_q     <= LoadTypeM;
            ld_flag_q   <= is_load;
            timed_out_q <= 1'b0;
            cnt_q       <= '0;
          end
        end
        BUSY: begin
          // An ack in the final allowed cycle beats the timeout.
          if (dmem.DMemAck) begin
            state <= DONE;
            req_q <= 1'b0;
            we_q  <= 4'b0000;
            if (ld_flag_q) rdata_q <= dmem.DMemRData;
          end else if (TO_EN && (cnt_q == TO_LAST)) begin
            state       <= DONE;
            req_q       <= 1'b0;
            we_q        <= 4'b0000;
            BusErr      <= 1'b1;
            timed_out_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          if (ld_flag_q && !timed_out_q) begin
            LoadValidW         <= 1'b1;
            LoadDataW          <= rdata_q;
            LoadedBytesSelectW <= bsel_q;
            LoadTypeW          <= ltype_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: vector table plus hand-built
// timeout / reset / back-to-back sequences, with bus and load scoreboards.
module tb_dmem_access_unit;
  import dmem_access_unit_pkg::*;

  localparam int TO = 8;

  logic        clk;
  logic        CPU_RSTn;
  logic        MemReadM;
  logic [2:0]  LoadTypeM;
  logic [1:0]  StoreTypeM;
  logic [31:0] AddrM;
  logic [31:0] StoreDataM;
  logic        StallMem;
  logic        MisalignM;
  logic        BusErr;
  logic [31:0] LoadDataW;
  logic [1:0]  LoadedBytesSelectW;
  logic [2:0]  LoadTypeW;
  logic        LoadValidW;
  state_t      dbg_state;

  dmem_access_unit_if #(.ADDR_W(32)) dif ();

  dmem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .CPU_CLK            (clk),
    .CPU_RSTn           (CPU_RSTn),
    .MemReadM           (MemReadM),
    .LoadTypeM          (LoadTypeM),
    .StoreTypeM         (StoreTypeM),
    .AddrM              (AddrM),
    .StoreDataM         (StoreDataM),
    .dmem               (dif.master),
    .StallMem           (StallMem),
    .MisalignM          (MisalignM),
    .BusErr             (BusErr),
    .LoadDataW          (LoadDataW),
    .LoadedBytesSelectW (LoadedBytesSelectW),
    .LoadTypeW          (LoadTypeW),
    .LoadValidW         (LoadValidW),
    .dbg_state          (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int compared   = 0;
  int mismatched = 0;
  int be_cnt     = 0;

  logic [65:0] exp_q[$];   // {word addr, we, wdata} per issued request
  logic [36:0] ld_q[$];    // {data, byte select, load type} per valid load
  logic [65:0] cur_bus;
  logic        req_prev;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  initial begin
    req_prev = 1'b0;
    cur_bus  = '0;
  end

  always @(posedge clk) begin
    #1;
    if (dif.DMemReq && !req_prev) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL bus_unexpected_req: got addr %0h we %b, expected no request",
                 dif.DMemAddr, dif.DMemWe);
      end else begin
        cur_bus = exp_q.pop_front();
        check("bus_req", 96'({dif.DMemAddr, dif.DMemWe, dif.DMemWData}), 96'(cur_bus));
      end
    end else if (dif.DMemReq) begin
      check("bus_hold", 96'({dif.DMemAddr, dif.DMemWe, dif.DMemWData}), 96'(cur_bus));
    end
    req_prev = dif.DMemReq;
    if (LoadValidW) begin
      if (ld_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL load_unexpected: got data %0h valid 1, expected valid 0", LoadDataW);
      end else begin
        check("load_w", 96'({LoadDataW, LoadedBytesSelectW, LoadTypeW}), 96'(ld_q.pop_front()));
      end
    end
    if (BusErr) be_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic mr, input logic [2:0] lt, input logic [1:0] st,
                       input logic [31:0] addr, input logic [31:0] sd);
    MemReadM   = mr;
    LoadTypeM  = lt;
    StoreTypeM = st;
    AddrM      = addr;
    StoreDataM = sd;
  endtask

  // Presents one instruction in an IDLE cycle, acks in BUSY cycle ack_at
  // (0 = never), returns mid-cycle once StallMem has fallen; inputs stay held.
  task automatic do_op(input logic mr, input logic [2:0] lt, input logic [1:0] st,
                       input logic [31:0] addr, input logic [31:0] sd,
                       input int ack_at, input logic [31:0] rd,
                       output logic mis, output int stall);
    bit done;
    @(negedge clk);
    drive(mr, lt, st, addr, sd);
    #1;
    mis   = MisalignM;
    stall = 0;
    done  = 1'b0;
    if (StallMem) begin
      stall = 1;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        dif.DMemAck   = (k == ack_at);
        dif.DMemRData = rd;
        #1;
        if (!StallMem) begin
          done = 1'b1;
          break;
        end
        stall++;
      end
      dif.DMemAck = 1'b0;
      if (!done) check("stall_bound", 96'(stall), 96'(0));
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        mr;
    logic [2:0]  lt;
    logic [1:0]  st;
    logic [31:0] addr;
    logic [31:0] sd;
    int          ack_at;
    logic [31:0] rd;
    logic        exp_mis;
    logic [3:0]  exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[14];

  initial begin
    logic mis;
    int   stall;
    int   exp_stall;
    logic acc;

    dif.DMemAck   = 1'b0;
    dif.DMemRData = 32'h0;
    CPU_RSTn      = 1'b0;
    drive(1'b0, NOREGWRITE, SNONE, 32'h0, 32'h0);

    vecs[0]  = '{1'b0, NOREGWRITE, SB, 32'h1003, 32'h000000AB, 1, 32'h0,        1'b0, 4'b1000, 32'hABABABAB};
    vecs[1]  = '{1'b1, LH,         SNONE, 32'h2002, 32'h0,      4, 32'h80017FFF, 1'b0, 4'b0000, 32'h0};
    vecs[2]  = '{1'b1, LW,         SNONE, 32'h0006, 32'h0,      1, 32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[3]  = '{1'b0, NOREGWRITE, SH, 32'h0102, 32'h1234CDEF, 2, 32'h0,        1'b0, 4'b1100, 32'hCDEFCDEF};
    vecs[4]  = '{1'b0, NOREGWRITE, SH, 32'h0101, 32'h1234CDEF, 1, 32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[5]  = '{1'b0, NOREGWRITE, SW, 32'h0010, 32'hDEADBEEF, 1, 32'h0,        1'b0, 4'b1111, 32'hDEADBEEF};
    vecs[6]  = '{1'b1, LBU,        SNONE, 32'h0013, 32'h0,      1, 32'h11223344, 1'b0, 4'b0000, 32'h0};
    vecs[7]  = '{1'b0, NOREGWRITE, SW, 32'h0012, 32'h01020304, 1, 32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[8]  = '{1'b1, LHU,        SNONE, 32'h0003, 32'h0,      1, 32'h0,        1'b1, 4'b0000, 32'h0};
    vecs[9]  = '{1'b0, NOREGWRITE, SB, 32'h0000, 32'h0000005A, 3, 32'h0,        1'b0, 4'b0001, 32'h5A5A5A5A};
    vecs[10] = '{1'b1, LW,         SB, 32'h0005, 32'h00000077, 1, 32'h99999999, 1'b0, 4'b0010, 32'h77777777};
    vecs[11] = '{1'b1, LB,         SNONE, 32'h0001, 32'h0,      2, 32'hCAFEF00D, 1'b0, 4'b0000, 32'h0};
    vecs[12] = '{1'b0, NOREGWRITE, SNONE, 32'h0044, 32'h0,      1, 32'h0,        1'b0, 4'b0000, 32'h0};
    vecs[13] = '{1'b1, LW,         SNONE, 32'h0008, 32'h0,      TO, 32'h5EED1234, 1'b0, 4'b0000, 32'h0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   96'(dif.DMemReq),   96'(0));
    check("rst_we",    96'(dif.DMemWe),    96'(0));
    check("rst_addr",  96'(dif.DMemAddr),  96'(0));
    check("rst_wdata", 96'(dif.DMemWData), 96'(0));
    check("rst_buserr", 96'(BusErr), 96'(0));
    check("rst_w", 96'({LoadDataW, LoadedBytesSelectW, LoadTypeW, LoadValidW}), 96'(0));
    check("rst_stall", 96'(StallMem), 96'(0));
    check("rst_state", 96'(dbg_state), 96'(IDLE));
    @(negedge clk);
    CPU_RSTn = 1'b1;

    // Table-driven vectors (consecutive rows run back-to-back)
    for (int i = 0; i < 14; i++) begin
      acc = vecs[i].mr || (vecs[i].st != SNONE);
      if (vecs[i].mr && vecs[i].st != SNONE)
        $display("note: row %0d drives a load and a store together (illegal); store takes priority", i);
      exp_stall = (acc && !vecs[i].exp_mis) ? vecs[i].ack_at + 1 : 0;
      if (acc && !vecs[i].exp_mis) begin
        exp_q.push_back({vecs[i].addr[31:2], vecs[i].exp_we, vecs[i].exp_wdata});
        if (vecs[i].mr && vecs[i].st == SNONE)
          ld_q.push_back({vecs[i].rd, vecs[i].addr[1:0], vecs[i].lt});
      end
      do_op(vecs[i].mr, vecs[i].lt, vecs[i].st, vecs[i].addr, vecs[i].sd,
            vecs[i].ack_at, vecs[i].rd, mis, stall);
      check($sformatf("row%0d_misalign", i), 96'(mis), 96'(vecs[i].exp_mis));
      check($sformatf("row%0d_stall", i), 96'(stall), 96'(exp_stall));
      check($sformatf("row%0d_buserr", i), 96'(BusErr), 96'(0));
    end

    // Timeout: no ack for TO BUSY cycles
    exp_q.push_back({30'h8, 4'b0000, 32'h0});
    do_op(1'b1, LW, SNONE, 32'h20, 32'h0, 0, 32'h0, mis, stall);
    check("to_stall", 96'(stall), 96'(TO + 1));
    check("to_buserr", 96'(BusErr), 96'(1));
    check("to_req", 96'(dif.DMemReq), 96'(0));
    @(negedge clk);
    drive(1'b0, NOREGWRITE, SNONE, 32'h0, 32'h0);
    #1;
    check("to_buserr_pulse", 96'(BusErr), 96'(0));
    check("to_state", 96'(dbg_state), 96'(IDLE));

    // Reset in the 2nd BUSY cycle, late ack after release
    @(negedge clk);
    exp_q.push_back({30'h10, 4'b0000, 32'h0});
    drive(1'b1, LW, SNONE, 32'h40, 32'h0);
    @(negedge clk);
    @(negedge clk);
    CPU_RSTn = 1'b0;
    #1;
    check("mid_rst_req",   96'(dif.DMemReq),   96'(0));
    check("mid_rst_addr",  96'(dif.DMemAddr),  96'(0));
    check("mid_rst_stall", 96'(StallMem),      96'(0));
    check("mid_rst_state", 96'(dbg_state),     96'(IDLE));
    @(negedge clk);
    CPU_RSTn = 1'b1;
    drive(1'b0, NOREGWRITE, SNONE, 32'h0, 32'h0);
    @(negedge clk);
    dif.DMemAck   = 1'b1;
    dif.DMemRData = 32'hFFFFFFFF;
    @(negedge clk);
    dif.DMemAck = 1'b0;
    #1;
    check("late_ack_req",   96'(dif.DMemReq), 96'(0));
    check("late_ack_state", 96'(dbg_state),   96'(IDLE));
    check("late_ack_w",     96'(LoadValidW),  96'(0));
    repeat (3) @(negedge clk);

    // Closing checks
    check("bus_q_drained", 96'(exp_q.size()), 96'(0));
    check("ld_q_drained",  96'(ld_q.size()),  96'(0));
    check("buserr_pulses", 96'(be_cnt),       96'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
